// File: rtl/frame_write_addresser_pkg.sv
// Shared types and address helpers for the frame write addresser.
// Holds the FSM state encoding and the bank-offset arithmetic used for DDR placement.
package frame_write_addresser_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } wr_state_t;

    localparam int DEF_FRAME_CHUNKS = 3600;
    localparam int DEF_ADDR_STEP    = 8;
    localparam int BANK_OFFSET      = DEF_FRAME_CHUNKS * DEF_ADDR_STEP;

    // Bank 1 starts one full frame of chunks past bank 0.
    function automatic int bank_offset(input int frame_chunks, input int addr_step);
        return frame_chunks * addr_step;
    endfunction

endpackage

// File: rtl/frame_write_addresser.sv
// Attaches double-buffered DDR write addresses to 128-bit chunks and drives the MIG write port.
// Realigns on chunk_tlast; the output stage is a single-register AXIS slice.
module frame_write_addresser
    import frame_write_addresser_pkg::*;
#(
    parameter int FRAME_CHUNKS = DEF_FRAME_CHUNKS,
    parameter int ADDR_STEP    = DEF_ADDR_STEP,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_W       = 27
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              chunk_tvalid,
    output logic              chunk_tready,
    input  logic [127:0]      chunk_tdata,
    input  logic              chunk_tlast,
    output logic              mig_wr_valid,
    input  logic              mig_wr_ready,
    output logic [ADDR_W-1:0] mig_wr_addr,
    output logic [127:0]      mig_wr_data,
    output logic              frame_done,
    output logic              frame_bank,
    output logic              sync_err
);

    localparam int IDX_W = (FRAME_CHUNKS > 2) ? $clog2(FRAME_CHUNKS) : 1;
    localparam logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BANK1_BASE =
        ADDR_W'(BASE_ADDR + bank_offset(FRAME_CHUNKS, ADDR_STEP));
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_CHUNKS - 1);

    wr_state_t         state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic              wr_bank_reg;
    logic [ADDR_W-1:0] next_addr_reg;
    logic              acc;
    logic              at_last;

    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? BANK1_BASE : BANK0_BASE;
    endfunction

    // SYNC never stalls the source: chunks there are discarded anyway.
    assign chunk_tready = (state_reg == SYNC) || !mig_wr_valid || mig_wr_ready;
    assign acc          = chunk_tvalid && chunk_tready;
    assign at_last      = (idx_reg == LAST_IDX);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg <= SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SYNC: begin
                if (acc && chunk_tlast) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (acc && at_last && !chunk_tlast) begin
                    state_next = SYNC;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx_reg       <= '0;
            wr_bank_reg   <= 1'b0;
            next_addr_reg <= BANK0_BASE;
            mig_wr_valid  <= 1'b0;
            mig_wr_addr   <= '0;
            mig_wr_data   <= '0;
            frame_done    <= 1'b0;
            frame_bank    <= 1'b1;
            sync_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state_reg == SYNC) begin
                if (acc && chunk_tlast) begin
                    idx_reg       <= '0;
                    next_addr_reg <= bank_base(wr_bank_reg);
                end
            end else if (acc) begin
                if (at_last && chunk_tlast) begin
                    idx_reg       <= '0;
                    wr_bank_reg   <= !wr_bank_reg;
                    next_addr_reg <= bank_base(!wr_bank_reg);
                    frame_done    <= 1'b1;
                    frame_bank    <= wr_bank_reg;
                end else if (!at_last && !chunk_tlast) begin
                    idx_reg       <= idx_reg + IDX_W'(1);
                    next_addr_reg <= next_addr_reg + STEP;
                end else begin
                    // Short or long frame: rewrite the same bank from its base.
                    sync_err      <= 1'b1;
                    idx_reg       <= '0;
                    next_addr_reg <= bank_base(wr_bank_reg);
                end
            end

            // Output slice: a pending word drains even after falling back to SYNC.
            if (state_reg == RUN && acc) begin
                mig_wr_valid <= 1'b1;
                mig_wr_addr  <= next_addr_reg;
                mig_wr_data  <= chunk_tdata;
            end else if (mig_wr_ready) begin
                mig_wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_write_addresser.sv
// Scoreboard bench for frame_write_addresser with a 4-chunk frame geometry.
// Table vectors cover sync and back-to-back frames; hand sequences cover stall, misalignment and reset.
module tb_frame_write_addresser;

    localparam int AW = 27;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           chunk_tvalid;
    logic           chunk_tready;
    logic [127:0]   chunk_tdata;
    logic           chunk_tlast;
    logic           mig_wr_valid;
    logic           mig_wr_ready;
    logic [AW-1:0]  mig_wr_addr;
    logic [127:0]   mig_wr_data;
    logic           frame_done;
    logic           frame_bank;
    logic           sync_err;

    always #5 clk_in = ~clk_in;

    frame_write_addresser #(
        .FRAME_CHUNKS(4),
        .ADDR_STEP   (8),
        .BASE_ADDR   (0),
        .ADDR_W      (AW)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .chunk_tvalid(chunk_tvalid),
        .chunk_tready(chunk_tready),
        .chunk_tdata (chunk_tdata),
        .chunk_tlast (chunk_tlast),
        .mig_wr_valid(mig_wr_valid),
        .mig_wr_ready(mig_wr_ready),
        .mig_wr_addr (mig_wr_addr),
        .mig_wr_data (mig_wr_data),
        .frame_done  (frame_done),
        .frame_bank  (frame_bank),
        .sync_err    (sync_err)
    );

    typedef struct {
        logic [127:0]  data;
        logic          last;
        logic          wr;
        logic [AW-1:0] addr;
        logic          done;
        logic          bank;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic          done;
        logic          bank;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total  = 0;
    int   passed = 0;
    logic pend_done = 1'b0;
    logic pend_bank = 1'b0;
    int   serial = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] mk_data(input int n);
        return {32'hA5A5_5A5A, 32'(n * 7 + 3), 32'hC0DE_0000, 32'(n)};
    endfunction

    // Monitor: one line per completed write, compared against the scoreboard head.
    always @(negedge clk_in) begin
        exp_t e;
        if (frame_done) begin
            pend_done = 1'b1;
            pend_bank = frame_bank;
        end
        if (mig_wr_valid && mig_wr_ready && rst_in) begin
            $display("write addr=%0d data=%h done=%0b bank=%0b", mig_wr_addr, mig_wr_data,
                     pend_done, pend_bank);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", mig_wr_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 128'(mig_wr_addr), 128'(e.addr));
                chk("wr_data", mig_wr_data, e.data);
                chk("frame_done", 128'(pend_done), 128'(e.done));
                if (e.done) chk("frame_bank", 128'(pend_bank), 128'(e.bank));
            end
            pend_done = 1'b0;
        end
    end

    task automatic send(input logic [127:0] d, input logic l, input logic wr,
                        input logic [AW-1:0] a, input logic dn, input logic bk,
                        output int waited);
        exp_t e;
        logic r;
        chunk_tvalid = 1'b1;
        chunk_tdata  = d;
        chunk_tlast  = l;
        if (wr) begin
            e.addr = a; e.data = d; e.done = dn; e.bank = bk;
            sb.push_back(e);
        end
        waited = 0;
        r = 1'b0;
        while (!r && waited < 50) begin
            @(negedge clk_in);
            r = chunk_tready;
            @(posedge clk_in);
            #1;
            waited++;
        end
        if (!r) begin
            total++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", waited);
        end
    endtask

    task automatic send_frame(input int n, input logic [AW-1:0] base, input logic bk);
        int w;
        for (int j = 0; j < n; j++) begin
            serial++;
            send(mk_data(serial), j == n - 1, 1'b1, base + AW'(j * 8), j == n - 1, bk, w);
        end
    endtask

    task automatic idle(input int n);
        chunk_tvalid = 1'b0;
        chunk_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drain();
        int c = 0;
        idle(1);
        while (sb.size() != 0 && c < 50) begin
            @(posedge clk_in);
            #1;
            c++;
        end
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vec_t v;
        rst_in       = 1'b0;
        chunk_tvalid = 1'b0;
        chunk_tdata  = '0;
        chunk_tlast  = 1'b0;
        mig_wr_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", 128'(mig_wr_valid), 128'(0));
        chk("rst_addr", 128'(mig_wr_addr), 128'(0));
        chk("rst_data", mig_wr_data, 128'(0));
        chk("rst_done", 128'(frame_done), 128'(0));
        chk("rst_bank", 128'(frame_bank), 128'(1));
        chk("rst_sync_err", 128'(sync_err), 128'(0));
        chk("rst_tready", 128'(chunk_tready), 128'(1));
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // Three discarded sync chunks, then frames in bank 0, 1, 0.
        for (int k = 0; k < 3; k++) begin
            v.data = mk_data(1000 + k); v.last = (k == 2); v.wr = 1'b0;
            v.addr = '0; v.done = 1'b0; v.bank = 1'b0;
            tbl.push_back(v);
        end
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 4; j++) begin
                v.data = mk_data(2000 + f * 4 + j); v.last = (j == 3); v.wr = 1'b1;
                v.addr = AW'((f % 2) * 32 + j * 8); v.done = (j == 3); v.bank = (f % 2 == 1);
                tbl.push_back(v);
            end
        end
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data, tbl[i].last, tbl[i].wr, tbl[i].addr, tbl[i].done, tbl[i].bank, w);
            chk("accept_one_cycle", 128'(w), 128'(1));
        end
        drain();
        chk("sync_err_clean", 128'(sync_err), 128'(0));

        // Stall in bank 1: hold chunk 1 for 5 cycles.
        serial++; send(mk_data(serial), 1'b0, 1'b1, 27'd32, 1'b0, 1'b0, w);
        serial++; send(mk_data(serial), 1'b0, 1'b1, 27'd40, 1'b0, 1'b0, w);
        mig_wr_ready = 1'b0;
        chunk_tvalid = 1'b1;
        chunk_tdata  = mk_data(serial + 1);
        chunk_tlast  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            chk("stall_tready", 128'(chunk_tready), 128'(0));
            chk("stall_valid", 128'(mig_wr_valid), 128'(1));
            chk("stall_addr", 128'(mig_wr_addr), 128'(40));
            chk("stall_data", mig_wr_data, mk_data(serial));
            @(posedge clk_in);
            #1;
        end
        mig_wr_ready = 1'b1;
        serial++; send(mk_data(serial), 1'b0, 1'b1, 27'd48, 1'b0, 1'b0, w);
        serial++; send(mk_data(serial), 1'b1, 1'b1, 27'd56, 1'b1, 1'b1, w);
        drain();

        // Short frame in bank 0: rewrite same base, no frame_done.
        serial++; send(mk_data(serial), 1'b0, 1'b1, 27'd0, 1'b0, 1'b0, w);
        serial++; send(mk_data(serial), 1'b1, 1'b1, 27'd8, 1'b0, 1'b0, w);
        drain();
        chk("short_sync_err", 128'(sync_err), 128'(1));
        send_frame(4, 27'd0, 1'b0);
        send_frame(4, 27'd32, 1'b1);
        drain();

        // Long frame in bank 0: 4th chunk written, 5th dropped in SYNC.
        for (int j = 0; j < 4; j++) begin
            serial++; send(mk_data(serial), 1'b0, 1'b1, AW'(j * 8), 1'b0, 1'b0, w);
        end
        serial++; send(mk_data(serial), 1'b1, 1'b0, 27'd0, 1'b0, 1'b0, w);
        send_frame(4, 27'd0, 1'b0);
        drain();

        // Reset while a write is stalled in bank 1.
        mig_wr_ready = 1'b0;
        serial++; send(mk_data(serial), 1'b0, 1'b0, 27'd32, 1'b0, 1'b0, w);
        chunk_tvalid = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_valid", 128'(mig_wr_valid), 128'(1));
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        pend_done = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_valid", 128'(mig_wr_valid), 128'(0));
        chk("mid_rst_addr", 128'(mig_wr_addr), 128'(0));
        chk("mid_rst_data", mig_wr_data, 128'(0));
        chk("mid_rst_bank", 128'(frame_bank), 128'(1));
        chk("mid_rst_sync_err", 128'(sync_err), 128'(0));
        chk("mid_rst_tready", 128'(chunk_tready), 128'(1));
        mig_wr_ready = 1'b1;
        @(posedge clk_in);
        #1;
        serial++; send(mk_data(serial), 1'b0, 1'b0, 27'd0, 1'b0, 1'b0, w);
        idle(3);
        @(negedge clk_in);
        chk("sync_no_write", 128'(mig_wr_valid), 128'(0));
        @(posedge clk_in);
        #1;
        serial++; send(mk_data(serial), 1'b1, 1'b0, 27'd0, 1'b0, 1'b0, w);
        send_frame(4, 27'd0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
